// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - ISA field widths, field positions, opcodes and encoder state encoding
package instr_encoder_pkg;
    localparam int INSTR_W  = 33;
    localparam int OPC_W    = 5;
    localparam int REG_W    = 4;
    localparam int IMM_W    = 16;

    localparam int OPC_LSB  = 28;
    localparam int DEST_LSB = 24;
    localparam int SRC1_LSB = 20;
    localparam int SRC2_LSB = 16;
    localparam int IMM_LSB  = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 5'd0,  OP_LR  = 5'd1,  OP_LI  = 5'd2,  OP_SR  = 5'd3,
        OP_MOVE = 5'd4,  OP_ADD = 5'd5,  OP_ADDI = 5'd6, OP_SUB = 5'd7,
        OP_CMP  = 5'd8,  OP_AND = 5'd9,  OP_OR  = 5'd10, OP_NOT = 5'd11,
        OP_SHL  = 5'd12, OP_SHR = 5'd13, OP_BNE = 5'd14, OP_BE  = 5'd15
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-tuple input stream and instruction-memory write port
interface instr_encoder_if #(
    parameter int MEM_ADDR_BITS     = 8,
    parameter int INSTRUCTION_WIDTH = 33
);
    import instr_encoder_pkg::*;

    logic                         in_valid;
    logic                         in_ready;
    logic [OPC_W-1:0]             in_opcode;
    logic [REG_W-1:0]             in_dest;
    logic [REG_W-1:0]             in_src1;
    logic [REG_W-1:0]             in_src2;
    logic [IMM_W-1:0]             in_imm;
    logic                         in_last;
    logic                         imem_we;
    logic [MEM_ADDR_BITS-1:0]     imem_addr;
    logic [INSTRUCTION_WIDTH-1:0] imem_wdata;

    modport master (
        output in_valid, in_opcode, in_dest, in_src1, in_src2, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_opcode, in_dest, in_src1, in_src2, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational field packer: tuple fields to 33-bit word plus opcode-valid flag
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode,
    input  logic [REG_W-1:0]   dest,
    input  logic [REG_W-1:0]   src1,
    input  logic [REG_W-1:0]   src2,
    input  logic [IMM_W-1:0]   imm,
    output logic [INSTR_W-1:0] word,
    output logic               valid
);
    always_comb begin
        word  = '0;
        valid = 1'b1;
        word[OPC_LSB +: OPC_W] = opcode;
        case (opcode)
            OP_NOP: ;
            OP_LI, OP_ADDI: begin
                word[DEST_LSB +: REG_W] = dest;
                word[IMM_LSB  +: IMM_W] = imm;
            end
            OP_LR, OP_SR, OP_SHL, OP_SHR, OP_BE, OP_BNE: begin
                word[DEST_LSB +: REG_W] = dest;
                word[SRC1_LSB +: REG_W] = src1;
                word[IMM_LSB  +: IMM_W] = imm;
            end
            OP_MOVE, OP_NOT: begin
                word[DEST_LSB +: REG_W] = dest;
                word[SRC1_LSB +: REG_W] = src1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                word[DEST_LSB +: REG_W] = dest;
                word[SRC1_LSB +: REG_W] = src1;
                word[SRC2_LSB +: REG_W] = src2;
            end
            // CMP has no destination: its two sources shift up into the dest/src1 slots
            OP_CMP: begin
                word[DEST_LSB +: REG_W] = src1;
                word[SRC1_LSB +: REG_W] = src2;
            end
            default: begin
                word  = '0;
                valid = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - loads encoded instructions into instruction memory from a field-tuple stream
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int MEM_ADDR_BITS     = 8,
    parameter int INSTRUCTION_WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [MEM_ADDR_BITS-1:0] base_addr,
    instr_encoder_if.slave           bus,
    output logic                     busy,
    output logic                     done,
    output logic                     err_opcode,
    output logic                     err_full,
    output logic [MEM_ADDR_BITS:0]   count
);
    localparam logic [MEM_ADDR_BITS-1:0] ADDR_MAX = '1;

    state_e                       state;
    logic [MEM_ADDR_BITS-1:0]     ptr;
    logic [MEM_ADDR_BITS:0]       cnt;
    logic                         we_q;
    logic [MEM_ADDR_BITS-1:0]     addr_q;
    logic [INSTRUCTION_WIDTH-1:0] wdata_q;
    logic                         err_op_q;
    logic                         err_full_q;
    logic [INSTR_W-1:0]           packed_word;
    logic                         op_ok;

    instr_pack u_pack (
        .opcode (bus.in_opcode),
        .dest   (bus.in_dest),
        .src1   (bus.in_src1),
        .src2   (bus.in_src2),
        .imm    (bus.in_imm),
        .word   (packed_word),
        .valid  (op_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            err_op_q   <= 1'b0;
            err_full_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        ptr        <= base_addr;
                        cnt        <= '0;
                        err_op_q   <= 1'b0;
                        err_full_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        if (op_ok) begin
                            we_q    <= 1'b1;
                            addr_q  <= ptr;
                            wdata_q <= INSTRUCTION_WIDTH'(packed_word);
                            cnt     <= cnt + 1'b1;
                            // The pointer parks on the last address instead of wrapping
                            if (bus.in_last) begin
                                state <= ST_FLUSH;
                            end else if (ptr == ADDR_MAX) begin
                                err_full_q <= 1'b1;
                                state      <= ST_FLUSH;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end else begin
                            err_op_q <= 1'b1;
                            if (bus.in_last) state <= ST_DONE;
                        end
                    end
                end
                ST_FLUSH: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state == ST_LOAD);
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state == ST_LOAD) || (state == ST_FLUSH);
    assign done           = (state == ST_DONE);
    assign err_opcode     = err_op_q;
    assign err_full       = err_full_q;
    assign count          = cnt;
endmodule
